// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: tick/mode inputs and register-file control outputs of the calculation sequencer
interface calc_sequencer_if #(parameter int W = 5);
    logic         tick;
    logic         sw;
    logic         hold;
    logic         op_valid;
    logic         wr_en;
    logic [W-1:0] wr_addr;
    logic [W-1:0] addr_rs1;
    logic [W-1:0] addr_rs2;
    logic         mux_sel;
    logic         read_mode;
    logic         filled;
    logic         pass_done;
    logic [2:0]   state_leds;
    modport master (
        input  tick, sw, hold, op_valid,
        output wr_en, wr_addr, addr_rs1, addr_rs2, mux_sel, read_mode, filled, pass_done, state_leds
    );
    modport slave (
        output tick, sw, hold, op_valid,
        input  wr_en, wr_addr, addr_rs1, addr_rs2, mux_sel, read_mode, filled, pass_done, state_leds
    );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: tick-driven scheduler for register-file writes, operand addresses and mode LEDs
module calc_sequencer #(
    parameter int W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    calc_sequencer_if.master      bus
);
    localparam logic [W-1:0] NREG    = W'(2**W - 1);
    localparam logic [1:0]   S_IDLE  = 2'd0;
    localparam logic [1:0]   S_FILL  = 2'd1;
    localparam logic [1:0]   S_COMP  = 2'd2;
    localparam logic [1:0]   S_PAUSE = 2'd3;

    logic [1:0]   state, state_n, tgt;
    logic         wr_en, wr_en_n, mux_sel, mux_n;
    logic [W-1:0] ptr, ptr_n, rs1, rs2, fill_cnt;
    logic         filled, pass_done, read_mode;
    logic [2:0]   leds;
    logic         fill_wr;

    assign tgt     = (bus.sw && filled) ? S_COMP : S_FILL;
    assign fill_wr = wr_en && !mux_sel;
    assign ptr_n   = wr_en ? ((ptr == NREG) ? W'(1) : ptr + W'(1)) : ptr;

    // next mode and write request; hold overrides any tick outside IDLE
    always_comb begin
        state_n = state;
        mux_n   = mux_sel;
        wr_en_n = 1'b0;
        if (state == S_IDLE) begin
            if (bus.tick && !bus.hold) begin
                state_n = S_FILL;
                mux_n   = 1'b0;
                wr_en_n = 1'b1;
            end
        end else if (bus.hold) begin
            state_n = S_PAUSE;
        end else if (state == S_PAUSE) begin
            state_n = tgt;
            mux_n   = (tgt == S_COMP);
        end else if (bus.tick) begin
            state_n = tgt;
            mux_n   = (tgt == S_COMP);
            wr_en_n = (tgt == S_FILL) || bus.op_valid;
        end
    end

    // registered state, pointer with trailing operand addresses, fill tracking and decoded outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            wr_en     <= 1'b0;
            mux_sel   <= 1'b0;
            ptr       <= W'(1);
            rs1       <= NREG - W'(1);
            rs2       <= NREG;
            fill_cnt  <= '0;
            filled    <= 1'b0;
            pass_done <= 1'b0;
            read_mode <= 1'b1;
            leds      <= 3'b000;
        end else begin
            state     <= state_n;
            wr_en     <= wr_en_n;
            mux_sel   <= mux_n;
            ptr       <= ptr_n;
            rs1       <= (ptr_n == W'(1)) ? NREG - W'(1) : (ptr_n == W'(2)) ? NREG : ptr_n - W'(2);
            rs2       <= (ptr_n == W'(1)) ? NREG : ptr_n - W'(1);
            fill_cnt  <= (fill_wr && fill_cnt != NREG) ? fill_cnt + W'(1) : fill_cnt;
            filled    <= filled || (fill_wr && fill_cnt == NREG - W'(1));
            pass_done <= wr_en && (ptr == NREG);
            read_mode <= (state_n == S_IDLE) || (state_n == S_PAUSE);
            leds      <= (state_n == S_FILL) ? 3'b001 : (state_n == S_COMP) ? 3'b010 :
                         (state_n == S_PAUSE) ? 3'b100 : 3'b000;
        end
    end

    assign bus.wr_en      = wr_en;
    assign bus.wr_addr    = ptr;
    assign bus.addr_rs1   = rs1;
    assign bus.addr_rs2   = rs2;
    assign bus.mux_sel    = mux_sel;
    assign bus.read_mode  = read_mode;
    assign bus.filled     = filled;
    assign bus.pass_done  = pass_done;
    assign bus.state_leds = leds;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed checks of fill, compute, op-less ticks, back-to-back ticks, hold and reset
module tb_calc_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   e1[3] = '{30, 31, 1};
    int   e2[3] = '{31, 1, 2};

    calc_sequencer_if #(.W(5)) bus();
    calc_sequencer #(.W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_tick(input logic ov);
        @(negedge clk);
        bus.tick = 1'b1;
        bus.op_valid = ov;
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.tick = 1'b0;
        bus.sw = 1'b0;
        bus.hold = 1'b0;
        bus.op_valid = 1'b0;
        cyc();
        chk("rst wr_en", bus.wr_en, 0);
        chk("rst wr_addr", bus.wr_addr, 1);
        chk("rst rs1", bus.addr_rs1, 30);
        chk("rst rs2", bus.addr_rs2, 31);
        chk("rst leds", bus.state_leds, 3'b000);
        chk("rst read_mode", bus.read_mode, 1);
        chk("rst filled", bus.filled, 0);
        chk("rst pass_done", bus.pass_done, 0);
        chk("rst mux_sel", bus.mux_sel, 0);
        @(negedge clk);
        rst = 1'b1;
        // reset asserted in the middle of a write cycle
        do_tick(1'b0);
        chk("first wr_en", bus.wr_en, 1);
        chk("first wr_addr", bus.wr_addr, 1);
        chk("first leds", bus.state_leds, 3'b001);
        chk("first read_mode", bus.read_mode, 0);
        #2 rst = 1'b0;
        #1;
        chk("midrst wr_en", bus.wr_en, 0);
        chk("midrst wr_addr", bus.wr_addr, 1);
        chk("midrst rs1", bus.addr_rs1, 30);
        chk("midrst rs2", bus.addr_rs2, 31);
        chk("midrst leds", bus.state_leds, 3'b000);
        chk("midrst read_mode", bus.read_mode, 1);
        @(negedge clk);
        rst = 1'b1;
        // full random fill pass
        for (int i = 1; i <= 31; i++) begin
            do_tick(1'b0);
            chk($sformatf("fill%0d wr_en", i), bus.wr_en, 1);
            chk($sformatf("fill%0d wr_addr", i), bus.wr_addr, i);
            chk($sformatf("fill%0d mux_sel", i), bus.mux_sel, 0);
            cyc();
            chk($sformatf("fill%0d wr_en off", i), bus.wr_en, 0);
            chk($sformatf("fill%0d pass_done", i), bus.pass_done, (i == 31) ? 1 : 0);
            chk($sformatf("fill%0d filled", i), bus.filled, (i == 31) ? 1 : 0);
        end
        chk("wrap wr_addr", bus.wr_addr, 1);
        cyc();
        chk("pass_done pulse", bus.pass_done, 0);
        // compute mode with operands trailing the pointer
        bus.sw = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            do_tick(1'b1);
            chk($sformatf("comp%0d wr_en", i), bus.wr_en, 1);
            chk($sformatf("comp%0d wr_addr", i), bus.wr_addr, i);
            chk($sformatf("comp%0d mux_sel", i), bus.mux_sel, 1);
            chk($sformatf("comp%0d rs1", i), bus.addr_rs1, e1[i-1]);
            chk($sformatf("comp%0d rs2", i), bus.addr_rs2, e2[i-1]);
            chk($sformatf("comp%0d leds", i), bus.state_leds, 3'b010);
            cyc();
        end
        // tick without a selected operation is consumed silently
        do_tick(1'b0);
        chk("noop wr_en", bus.wr_en, 0);
        chk("noop wr_addr", bus.wr_addr, 4);
        chk("noop leds", bus.state_leds, 3'b010);
        cyc();
        do_tick(1'b1);
        chk("op wr_en", bus.wr_en, 1);
        chk("op wr_addr", bus.wr_addr, 4);
        chk("op rs1", bus.addr_rs1, 2);
        chk("op rs2", bus.addr_rs2, 3);
        cyc();
        // back-to-back ticks
        do_tick(1'b1);
        chk("b2b first wr_addr", bus.wr_addr, 5);
        do_tick(1'b1);
        chk("b2b second wr_en", bus.wr_en, 1);
        chk("b2b second wr_addr", bus.wr_addr, 6);
        cyc();
        chk("b2b end wr_en", bus.wr_en, 0);
        chk("b2b end wr_addr", bus.wr_addr, 7);
        // new reset: hold in IDLE, then sw=1 before filled stays in FILL
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.hold = 1'b1;
        do_tick(1'b0);
        chk("idle hold leds", bus.state_leds, 3'b000);
        chk("idle hold wr_en", bus.wr_en, 0);
        bus.hold = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            do_tick(1'b0);
            chk($sformatf("early%0d wr_addr", i), bus.wr_addr, i);
            chk($sformatf("early%0d mux_sel", i), bus.mux_sel, 0);
            chk($sformatf("early%0d leds", i), bus.state_leds, 3'b001);
            cyc();
        end
        // hold coincident with tick at pointer 7
        @(negedge clk);
        bus.hold = 1'b1;
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        chk("hold wr_en", bus.wr_en, 0);
        chk("hold leds", bus.state_leds, 3'b100);
        chk("hold read_mode", bus.read_mode, 1);
        chk("hold wr_addr", bus.wr_addr, 7);
        chk("hold mux_sel", bus.mux_sel, 0);
        do_tick(1'b1);
        chk("pause tick wr_en", bus.wr_en, 0);
        do_tick(1'b1);
        chk("pause tick2 wr_en", bus.wr_en, 0);
        chk("pause wr_addr", bus.wr_addr, 7);
        @(negedge clk);
        bus.hold = 1'b0;
        cyc();
        chk("resume wr_en", bus.wr_en, 0);
        chk("resume leds", bus.state_leds, 3'b001);
        chk("resume read_mode", bus.read_mode, 0);
        do_tick(1'b0);
        chk("resume write wr_en", bus.wr_en, 1);
        chk("resume write wr_addr", bus.wr_addr, 7);
        chk("resume write rs1", bus.addr_rs1, 5);
        chk("resume write rs2", bus.addr_rs2, 6);
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
